uart_word_rx: RTL and testbench
===============================

# uart_word_rx

Receive-side counterpart of the board's 8N1 UART word printer. Oversamples the asynchronous `uart_rx` pin, deserialises 8N1 frames LSB-first, and emits each byte with a one-cycle strobe. Bytes are packed into a 64-bit word, first byte in bits [7:0], so that a printer stream such as 42 41 42 41 42 41 42 0A reconstructs 64'h0A42414241424142. Sits between the top-level `uart_rx` pin and the LED/debug logic.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 217: clk cycles per UART bit (25 MHz / 115200). Must be ≥ 4.
- `IDLE_BITS`, default 20: idle timeout in bit periods. Used only with `UART_RX_TIMEOUT_EN`.

**Ports**
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: raw serial line, idle high, asynchronous to `clk`.
- `byte_data` out 8: last good byte. Held until the next good byte.
- `byte_valid` out 1: one-cycle strobe for a good byte.
- `word` out 64: last completed word. Held until the next completion.
- `word_valid` out 1: one-cycle strobe when the 8th byte lands.
- `frame_err` out 1: one-cycle strobe when a stop bit is sampled low.
- `byte_count` out 3: bytes held in the partial word (0–7).

## Operation

**Input synchroniser**
- `rx` passes through a 2-FF synchroniser; the result is `rx_s`.
- Both FFs reset to 1.

**Bit counter**
- `cnt` has width $clog2(CLKS_PER_BIT).
- HALF = CLKS_PER_BIT/2, integer division.

**FSM states: IDLE, START, DATA, STOP, RECOVER**
- IDLE: on `rx_s`==0, set `cnt`<=0 and go to START.
- START: at `cnt`==HALF-1, sample `rx_s`.
  - If 0: `cnt`<=0, bit index<=0, go to DATA.
  - If 1 (glitch): go to IDLE with no outputs.
- DATA: at `cnt`==CLKS_PER_BIT-1, shift `rx_s` into bit [7] of a right-shift register (LSB arrives first) and reset `cnt`. After bit index 7, go to STOP.
- STOP: at `cnt`==CLKS_PER_BIT-1, sample `rx_s`.
  - If 1: register the byte, pulse `byte_valid`, go to IDLE.
  - If 0: pulse `frame_err`, discard the byte, go to RECOVER.
- RECOVER: wait for `rx_s`==1, then go to IDLE. This prevents a break condition from being read as repeated start bits.

**Word assembler**
- A good byte is written to `word_buf[8*byte_count +: 8]`, and `byte_count` increments.
- When the byte is written with `byte_count`==7:
  - `word` <= completed buffer.
  - `word_valid` pulses in the same cycle as `byte_valid`.
  - `byte_count` wraps to 0.
- `frame_err` clears `byte_count` to 0. A partial word is never emitted.

**Reset values (all outputs)**
- `byte_data`=0, `byte_valid`=0, `word`=0, `word_valid`=0, `frame_err`=0, `byte_count`=0.
- FSM in IDLE, `cnt`=0, `word_buf`=0.
- Reset mid-frame aborts the frame and produces no strobes. The next frame after reset deassertion is received normally, provided it begins with a falling edge seen in IDLE.

## Timing

- Sample points, counted from the first cycle `rx_s` is low while in IDLE:
  - start bit at +HALF;
  - data bit k at +HALF+(k+1)·CLKS_PER_BIT;
  - stop bit at +HALF+9·CLKS_PER_BIT.
- `byte_valid`, `word_valid` and `frame_err` are registered and assert on the clk cycle after the stop-bit sample.
- Pin-to-strobe latency is HALF+9·CLKS_PER_BIT+3 cycles after `rx` falls. This counts 2 synchroniser cycles plus 1 registered strobe cycle. Benches allow ±1 cycle for pin/clock phase.
- Back-to-back frames: the FSM is back in IDLE half a bit into the stop bit, so the next start edge is accepted with zero idle bits.
- No backpressure. The consumer must take `byte_data`/`word` on the strobe cycle, or before the next strobe.
- `byte_valid` and `frame_err` are never high together.

## Configuration

- `UART_RX_TIMEOUT_EN` defined:
  - A counter runs while the FSM is in IDLE with `byte_count`≠0.
  - After IDLE_BITS·CLKS_PER_BIT consecutive idle cycles, `byte_count` is cleared to 0 and `word_buf` is zeroed. No strobe is issued.
  - The counter restarts on any start edge.
- `UART_RX_TIMEOUT_EN` undefined:
  - No timeout logic is built; `IDLE_BITS` is ignored.
  - A partial word persists indefinitely until it is completed, hit by a framing error, or reset.

## Test plan

All scenarios use CLKS_PER_BIT=8.

- **Single byte:** send 0x42 (8N1) → one `byte_valid` pulse with `byte_data`=0x42; `byte_count`=1; no `word_valid`.
- **Full word:** send 42 41 42 41 42 41 42 0A back-to-back with zero idle bits → 8 `byte_valid` pulses; one `word_valid` coincident with the 8th; `word`=64'h0A42414241424142; `byte_count`=0.
- **Framing error:** send 3 good bytes, then 0x55 with a low stop bit, holding `rx` low for 20 bits → `frame_err` pulses once; no `byte_valid` for 0x55; `byte_count`=0. Next byte 0xA5 → `byte_data`=0xA5, `byte_count`=1.
- **Glitch rejection:** drive `rx` low for 3 cycles (< HALF) → no strobes; FSM returns to IDLE; a following 0x0F is received correctly.
- **Reset mid-operation:** assert `rst` during data bit 4 of the 6th byte → all outputs read 0 while reset is held. After release, 8 fresh bytes 01..08 give `word`=64'h0807060504030201.
- **Timeout (macro on, IDLE_BITS=20):** send 2 bytes and idle 161 cycles → `byte_count`=0, no strobe. With the macro off, the same stimulus leaves `byte_count`=2.

Source files
------------

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs bytes LSB-byte-first into 64-bit words.
// Optional idle timeout on partial words: define UART_RX_TIMEOUT_EN.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int IDLE_BITS    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [63:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic [2:0]  byte_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  if (CLKS_PER_BIT < 4 || IDLE_BITS < 1) begin : g_bad_param
    $error("uart_word_rx: CLKS_PER_BIT must be >= 4 and IDLE_BITS >= 1");
  end

  logic             rx_p0, rx_p1;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [63:0]      word_buf;
  logic             tmo_hit;

  // Stage p0/p1: two-flop synchroniser, idle-high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_ff @(posedge clk) begin
    if (state == S_DATA && cnt == CNT_LAST)
      shreg <= {rx_s, shreg[7:1]};
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TMO_CYCLES = IDLE_BITS * CLKS_PER_BIT;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

  logic [TMO_W-1:0] idle_cnt;

  assign tmo_hit = (state == S_IDLE) && rx_s && (byte_count != 3'd0) &&
                   (idle_cnt == TMO_W'(TMO_CYCLES - 1));

  // Any start edge, busy state or empty word restarts the idle count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (state != S_IDLE || !rx_s || byte_count == 3'd0 || tmo_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      word       <= 64'd0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= 3'd0;
      word_buf   <= 64'd0;
    end else begin
      byte_valid <= 1'b0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            if (!rx_s) begin
              cnt     <= '0;
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7)
              state <= S_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_data                       <= shreg;
              byte_valid                      <= 1'b1;
              word_buf[{byte_count, 3'b000} +: 8] <= shreg;
              if (byte_count == 3'd7) begin
                word       <= {shreg, word_buf[55:0]};
                word_valid <= 1'b1;
              end
              // 3-bit count wraps 7 -> 0 on word completion
              byte_count <= byte_count + 1'b1;
              state      <= S_IDLE;
            end else begin
              frame_err  <= 1'b1;
              byte_count <= 3'd0;
              state      <= S_RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RECOVER: begin
          // A held-low line (break) must return high before a new start is armed
          if (rx_s)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (tmo_hit) begin
        byte_count <= 3'd0;
        word_buf   <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx with a queue-based byte/word model.
module tb_uart_word_rx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = HALF + 9 * CPB + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [63:0] word;
  logic        word_valid;
  logic        frame_err;
  logic [2:0]  byte_count;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .IDLE_BITS(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .word       (word),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         fall;
  } exp_t;

  exp_t        exq[$];
  logic [7:0]  mq[$];
  logic [63:0] m_word = 64'd0;
  logic [7:0]  m_data = 8'd0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_wv  = 0;
  int          wv_mark;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle: sample on the falling edge and compare against the model
  task automatic tick();
    exp_t        e;
    logic [63:0] w;
    bit          exp_wv;
    @(negedge clk);
    if (rst) begin
      exq.delete();
      mq.delete();
      m_word = 64'd0;
      m_data = 8'd0;
      check("rst_byte_valid", byte_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_word_valid", word_valid, 0);
      check("rst_byte_count", byte_count, 0);
      check("rst_word", word, 0);
      check("rst_byte_data", byte_data, 0);
    end else begin
      check("strobe_exclusive", byte_valid && frame_err, 0);
      if (word_valid) n_wv++;
      if (byte_valid || frame_err) begin
        if (exq.size() == 0) begin
          check("unexpected_strobe", {byte_valid, frame_err}, 0);
        end else begin
          e = exq.pop_front();
          n_cmp++;
          if (cyc - e.fall < LAT - 1 || cyc - e.fall > LAT + 1) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles required %0d+-1", cyc - e.fall, LAT);
          end
          check("strobe_kind_frame_err", frame_err, e.err);
          exp_wv = 1'b0;
          if (!e.err) begin
            check("byte_data_strobe", byte_data, e.data);
            mq.push_back(e.data);
            m_data = e.data;
            if (mq.size() == 8) begin
              w = 64'd0;
              foreach (mq[i]) w = w | (64'(mq[i]) << (8 * i));
              m_word = w;
              mq.delete();
              exp_wv = 1'b1;
            end
          end else begin
            mq.delete();
          end
          check("word_valid_strobe", word_valid, exp_wv);
          check("byte_count_strobe", byte_count, 64'(mq.size()));
        end
      end else begin
        check("word_valid_idle", word_valid, 0);
      end
      check("word_held", word, m_word);
      check("byte_data_held", byte_data, m_data);
      if (exq.size() > 0 && cyc - exq[0].fall > LAT + 1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_strobe: none by cycle %0d required near %0d", cyc, exq[0].fall + LAT);
        void'(exq.pop_front());
      end
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    exq.push_back('{err: !stop, data: data, fall: cyc});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    idle(2 * CPB);
  endtask

  logic [7:0] full_word [8] = '{8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h0A};
  logic [7:0] partial;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    check("reset_word", word, 64'd0);
    check("reset_count", byte_count, 0);
    rst = 1'b0;
    idle(2 * CPB);

    // Single byte
    wv_mark = n_wv;
    send_frame(8'h42, 1'b1);
    idle(2 * CPB);
    check("single_byte_data", byte_data, 8'h42);
    check("single_byte_count", byte_count, 1);
    check("single_no_word_valid", n_wv - wv_mark, 0);

    // Full word, zero idle bits between frames
    pulse_reset();
    wv_mark = n_wv;
    foreach (full_word[i]) send_frame(full_word[i], 1'b1);
    idle(2 * CPB);
    check("full_word", word, 64'h0A42414241424142);
    check("full_word_count", byte_count, 0);
    check("full_word_pulses", n_wv - wv_mark, 1);

    // Framing error with a 20-bit low line
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (19 * CPB) tick();
    idle(2 * CPB);
    check("ferr_count", byte_count, 0);
    check("ferr_byte_data_kept", byte_data, 8'h33);
    check("ferr_word_kept", word, 64'h0A42414241424142);
    send_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    check("after_ferr_data", byte_data, 8'hA5);
    check("after_ferr_count", byte_count, 1);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (3) tick();
    idle(3 * CPB);
    check("glitch_count", byte_count, 1);
    send_frame(8'h0F, 1'b1);
    idle(2 * CPB);
    check("glitch_next_data", byte_data, 8'h0F);
    check("glitch_next_count", byte_count, 2);

    // Reset during data bit 4 of the 6th byte
    pulse_reset();
    for (int i = 0; i < 5; i++) send_frame(8'hA0 + 8'(i), 1'b1);
    check("pre_reset_count", byte_count, 5);
    partial = 8'h06;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    rx = partial[4];
    repeat (HALF) tick();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) tick();
    check("midrst_byte_data", byte_data, 0);
    check("midrst_count", byte_count, 0);
    check("midrst_word", word, 0);
    rst = 1'b0;
    idle(2 * CPB);
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    idle(2 * CPB);
    check("post_reset_word", word, 64'h0807060504030201);
    check("post_reset_count", byte_count, 0);

    // Idle timeout on a partial word
    send_frame(8'hC3, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(161);
`ifdef UART_RX_TIMEOUT_EN
    check("timeout_count", byte_count, 0);
    mq.delete();
`else
    check("no_timeout_count", byte_count, 2);
`endif
    idle(2 * CPB);
    check("queue_drained", 64'(exq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
